// File: rtl/ram16k_loader.sv
// Byte-stream to 16-bit word loader / bulk clearer owning the data RAM write port.
// Word written 2 cycles after its second byte (1 word per 3 cycles); byte_ready drops while a word or clear is issued.
module ram16k_loader #(
  parameter int          ADDR_W      = 14,
  parameter int          DEPTH       = 16384,
  parameter logic [15:0] CLEAR_VALUE = 16'h0000,
  parameter bit          HI_FIRST    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_start,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              stream_end,
  output logic [15:0]       ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_HALF, S_WRITE, S_FLUSH, S_CLEAR, S_FINISH
  } state_t;

  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t              state_q;
  logic [7:0]          first_q;
  logic [15:0]         word_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W:0]     cnt_q;
  logic                end_q;
  logic                active_q;
  logic                ovf_q;
  logic [15:0]         ram_in_q;
  logic                ram_load_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic                done_q;

  logic        hs_d;
  logic        end_seen_d;
  logic [15:0] pair_d;
  logic [15:0] tail_d;

  assign byte_ready = (state_q == S_HALF) || (state_q == S_IDLE && !clear_start);
  assign hs_d       = byte_valid && byte_ready;
  assign end_seen_d = end_q || stream_end;
  assign pair_d     = HI_FIRST ? {first_q, byte_data} : {byte_data, first_q};
  assign tail_d     = HI_FIRST ? {first_q, 8'h00} : {8'h00, first_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      first_q    <= '0;
      word_q     <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      end_q      <= 1'b0;
      active_q   <= 1'b0;
      ovf_q      <= 1'b0;
      ram_in_q   <= '0;
      ram_load_q <= 1'b0;
      ram_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      ram_load_q <= 1'b0;
      done_q     <= (state_q == S_FINISH);
      case (state_q)
        S_IDLE: begin
          if (clear_start) begin
            state_q  <= S_CLEAR;
            ptr_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            end_q    <= 1'b0;
            active_q <= 1'b1;
          end else if (hs_d) begin
            // word_count keeps the previous load's total until a new load starts
            if (!active_q) cnt_q <= '0;
            first_q  <= byte_data;
            end_q    <= end_seen_d;
            active_q <= 1'b1;
            state_q  <= S_HALF;
          end else if (end_seen_d) begin
            state_q <= S_FINISH;
          end
        end
        S_HALF: begin
          if (hs_d) begin
            word_q  <= pair_d;
            end_q   <= end_seen_d;
            state_q <= S_WRITE;
          end else if (end_seen_d) begin
            word_q  <= tail_d;
            state_q <= S_FLUSH;
          end
        end
        S_WRITE, S_FLUSH: begin
          if (cnt_q < CNT_MAX) begin
            ram_load_q <= 1'b1;
            ram_addr_q <= cnt_q[ADDR_W-1:0];
            ram_in_q   <= word_q;
            cnt_q      <= cnt_q + CNT_ONE;
          end else begin
            ovf_q <= 1'b1;
          end
          if (state_q == S_FLUSH || end_seen_d) begin
            end_q   <= 1'b0;
            state_q <= S_FINISH;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CLEAR: begin
          ram_load_q <= 1'b1;
          ram_addr_q <= ptr_q;
          ram_in_q   <= CLEAR_VALUE;
          ptr_q      <= ptr_q + PTR_ONE;
          if (ptr_q == PTR_LAST) state_q <= S_FINISH;
        end
        S_FINISH: begin
          active_q <= 1'b0;
          end_q    <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_in      = ram_in_q;
  assign ram_load    = ram_load_q;
  assign ram_address = ram_addr_q;
  assign busy        = (state_q != S_IDLE) || active_q;
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign word_count  = cnt_q;

endmodule
